mod_sched: RTL and testbench

MOD_SCHED -- requirements
Module: mod_sched

---
 rtl/mod_sched.sv | 112 +++++++++++
 tb/tb_mod_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_sched.sv
// Two-requester round-robin scheduler driving an external
// repeated-subtraction A mod B datapath.
module mod_sched #(
    parameter int MAX_ITER = 65535,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic [1:0]  gnt,
    output logic        done0,
    output logic        done1,
    output logic [31:0] result,
    output logic        err,
    output logic        busy,
    output logic [31:0] dp_a,
    output logic [31:0] dp_b,
    output logic        dp_reset,
    output logic        dp_subtract_enable,
    input  logic        dp_lt,
    input  logic [31:0] dp_result
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SUB,
        CAPT,
        RESP
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_ITER - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             fail;
    logic             elig0;
    logic             elig1;
    logic             pick1;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;

    // A requester whose done is showing this cycle is still holding req.
    assign elig0 = req0 & ~done0;
    assign elig1 = req1 & ~done1;
    assign pick1 = elig1 & (~elig0 | ~last);
    assign sel_a = pick1 ? a1 : a0;
    assign sel_b = pick1 ? b1 : b0;

    assign busy               = (state != IDLE);
    assign dp_reset           = (state == LOAD);
    assign dp_subtract_enable = (state == SUB);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            gnt    <= 2'b00;
            done0  <= 1'b0;
            done1  <= 1'b0;
            result <= 32'd0;
            err    <= 1'b0;
            dp_a   <= 32'd0;
            dp_b   <= 32'd0;
            cnt    <= '0;
            fail   <= 1'b0;
            last   <= 1'b1;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (elig0 | elig1) begin
                        gnt   <= pick1 ? 2'b10 : 2'b01;
                        last  <= pick1;
                        dp_a  <= sel_a;
                        dp_b  <= sel_b;
                        cnt   <= '0;
                        fail  <= (sel_b == 32'd0);
                        state <= (sel_b == 32'd0) ? RESP : LOAD;
                    end
                end
                LOAD: state <= SUB;
                SUB: begin
                    cnt <= cnt + 1'b1;
                    if (dp_lt) begin
                        state <= CAPT;
                    end else if (cnt == LAST) begin
                        fail  <= 1'b1;
                        state <= RESP;
                    end
                end
                CAPT: state <= RESP;
                RESP: begin
                    result <= fail ? 32'd0 : dp_result;
                    err    <= fail;
                    done0  <= gnt[0];
                    done1  <= gnt[1];
                    gnt    <= 2'b00;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_sched.sv
// Randomised bench for mod_sched with a behavioural datapath,
// an arithmetic latency/result model and directed literal cases.
module tb_mod_sched;

    localparam int MAXI = 8;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  gnt;
    logic        done0, done1;
    logic [31:0] result;
    logic        err, busy;
    logic [31:0] dp_a, dp_b;
    logic        dp_reset, dp_subtract_enable;
    logic        dp_lt;
    logic [31:0] dp_result;

    int vectors;
    int miscompares;
    int cyc;

    mod_sched #(.MAX_ITER(MAXI), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt(gnt), .done0(done0), .done1(done1),
        .result(result), .err(err), .busy(busy),
        .dp_a(dp_a), .dp_b(dp_b),
        .dp_reset(dp_reset),
        .dp_subtract_enable(dp_subtract_enable),
        .dp_lt(dp_lt), .dp_result(dp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural datapath: registered remainder, flag and result.
    logic [31:0] rem;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem <= 0; dp_lt <= 0; dp_result <= 0;
        end else if (dp_reset) begin
            rem <= dp_a; dp_lt <= 0;
        end else if (dp_subtract_enable) begin
            if (rem < dp_b) dp_lt <= 1;
            else rem <= rem - dp_b;
        end else begin
            dp_result <= rem;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference model: one operation in flight, timing from arithmetic.
    bit          m_act;
    bit          m_own;
    bit          m_bz;
    int          m_c0, m_cd, m_se;
    logic [31:0] m_ores;
    logic        m_oerr;
    logic [31:0] m_res;
    logic        m_err;
    bit          m_last;
    logic [31:0] m_da, m_db;

    always @(negedge clk) begin
        bit inop, isdone, e0, e1, el0, el1, p1;
        logic [31:0] ga, gb, n;
        if (!reset) begin
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_done", 32'({done0, done1}), 0);
            chk("rst_result", result, 0);
            chk("rst_err", 32'(err), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_dp_a", dp_a, 0);
            chk("rst_dp_b", dp_b, 0);
            chk("rst_dp_ctl", 32'({dp_reset, dp_subtract_enable}), 0);
            m_act = 0; m_res = 0; m_err = 0; m_last = 1;
            m_da = 0; m_db = 0;
        end else begin
            inop   = m_act && cyc > m_c0 && cyc < m_cd;
            isdone = m_act && cyc == m_cd;
            if (isdone) begin
                m_res = m_ores; m_err = m_oerr;
            end
            e0 = isdone && !m_own;
            e1 = isdone && m_own;
            chk("gnt", 32'(gnt), inop ? (m_own ? 2 : 1) : 0);
            chk("done0", 32'(done0), 32'(e0));
            chk("done1", 32'(done1), 32'(e1));
            chk("busy", 32'(busy), 32'(inop));
            chk("result", result, m_res);
            chk("err", 32'(err), 32'(m_err));
            chk("dp_a", dp_a, m_da);
            chk("dp_b", dp_b, m_db);
            chk("dp_reset", 32'(dp_reset),
                32'(inop && !m_bz && cyc == m_c0 + 1));
            chk("dp_sub", 32'(dp_subtract_enable),
                32'(inop && !m_bz && cyc >= m_c0 + 2 && cyc <= m_se));
            if (!m_act || cyc >= m_cd) begin
                el0 = req0 && !e0;
                el1 = req1 && !e1;
                if (el0 || el1) begin
                    p1 = el1 && (!el0 || !m_last);
                    ga = p1 ? a1 : a0;
                    gb = p1 ? b1 : b0;
                    m_act = 1; m_own = p1; m_last = p1;
                    m_c0 = cyc; m_da = ga; m_db = gb;
                    m_bz = (gb == 0);
                    if (m_bz) begin
                        m_cd = cyc + 2; m_se = -1;
                        m_ores = 0; m_oerr = 1;
                    end else begin
                        n = ga / gb;
                        if (n >= MAXI - 1) begin
                            m_cd = cyc + MAXI + 3;
                            m_se = cyc + MAXI + 1;
                            m_ores = 0; m_oerr = 1;
                        end else begin
                            m_cd = cyc + int'(n) + 6;
                            m_se = cyc + int'(n) + 3;
                            m_ores = ga % gb; m_oerr = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic set_req(input int i, input logic v,
                           input logic [31:0] a, input logic [31:0] b);
        if (i == 0) begin req0 = v; a0 = a; b0 = b; end
        else        begin req1 = v; a1 = a; b1 = b; end
    endtask

    function automatic logic done_of(input int i);
        return (i == 0) ? done0 : done1;
    endfunction

    task automatic run_op(input int i, input logic [31:0] a,
                          input logic [31:0] b, input int lat_e,
                          input logic [31:0] res_e, input logic err_e,
                          input string nm);
        int lat;
        lat = 0;
        @(posedge clk); #1;
        set_req(i, 1, a, b);
        for (int k = 1; k <= 300 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (done_of(i)) lat = k;
        end
        set_req(i, 0, a, b);
        chk({nm, "_lat"}, 32'(lat), 32'(lat_e));
        chk({nm, "_res"}, result, res_e);
        chk({nm, "_err"}, 32'(err), 32'(err_e));
    endtask

    task automatic requester(input int i);
        logic [31:0] a, b;
        int got;
        for (int op = 0; op < 25; op++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            b = $urandom_range(0, 9);
            a = (b == 0) ? $urandom : $urandom_range(0, b * 11 - 1);
            set_req(i, 1, a, b);
            got = 0;
            for (int k = 0; k < 200 && got == 0; k++) begin
                @(posedge clk); #1;
                if (done_of(i)) got = 1;
            end
            chk($sformatf("req%0d_served", i), 32'(got), 1);
            set_req(i, 0, $urandom, $urandom);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int l0, l1;
        vectors = 0; miscompares = 0; cyc = 0;
        reset = 0;
        req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1;

        // Simultaneous requests straight out of reset: req0 wins.
        @(posedge clk); #1;
        set_req(0, 1, 17, 5);
        set_req(1, 1, 3, 7);
        l0 = 0; l1 = 0;
        for (int k = 1; k <= 100 && l1 == 0; k++) begin
            @(posedge clk); #1;
            if (done0) begin
                l0 = k;
                chk("both_res0", result, 2);
                set_req(0, 0, 0, 0);
            end
            if (done1) begin
                l1 = k;
                chk("both_res1", result, 3);
                set_req(1, 0, 0, 0);
            end
        end
        chk("both_lat0", 32'(l0), 9);
        chk("both_lat1", 32'(l1), 15);

        run_op(0, 17, 5, 9, 2, 0, "r17m5");
        run_op(1, 3, 7, 6, 3, 0, "r3m7");
        run_op(0, 42, 0, 2, 0, 1, "bzero");
        run_op(1, 0, 5, 6, 0, 0, "azero");
        run_op(0, 100, 1, MAXI + 3, 0, 1, "tmo");
        run_op(1, 6, 1, MAXI + 4, 0, 0, "edge_ok");
        run_op(0, 7, 1, MAXI + 3, 0, 1, "edge_tmo");
        run_op(1, 23, 4, 11, 3, 0, "r23m4");

        // Abort during SUB: everything clears at once, no done.
        @(posedge clk); #1;
        set_req(0, 1, 9, 2);
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        set_req(0, 0, 0, 0);
        #1;
        chk("abort_gnt", 32'(gnt), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_result", result, 0);
        chk("abort_dp_a", dp_a, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1;
        run_op(0, 20, 6, 9, 2, 0, "post_abort");

        fork
            requester(0);
            requester(1);
        join
        repeat (20) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
